// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mul_sequencer
//  Purpose  : Iterative shift-add multiply controller for the execute stage.
//             Borrows the shared execute-stage adder for one partial-product
//             step per cycle and stalls the pipeline while it does so.
//  Revision : 1.0 - initial release
// ============================================================================
module mul_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [WIDTH-1:0]   alu_sum,
    input  logic               alu_cout,
    output logic               alu_req,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    // Iteration counter only has to reach WIDTH-1.
    localparam int             c_CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [c_CW-1:0]    r_cnt;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_product;

    logic               w_running;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH:0]   w_shift;
    logic [2*WIDTH-1:0] w_step;

    assign w_running = (r_state == c_ST_RUN);
    // start is only honoured outside RUN; there is no request queue.
    assign w_accept  = start && !w_running;
    assign w_last    = w_running && (r_cnt == c_CNT_LAST);

    // Magnitudes for signed operation; the most negative value maps onto
    // itself, which is the correct unsigned magnitude.
    assign w_mag_a = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
    assign w_mag_b = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;

    // Carry from the shared adder lands in the top bit before the shift.
    assign w_shift = {alu_cout, alu_sum, r_lo};
    assign w_step  = w_shift[2*WIDTH:1];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and all externally visible control outputs.
    always_comb begin
        w_state_nxt = r_state;
        alu_req     = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                alu_req = 1'b1;
                busy    = 1'b1;
                alu_a   = r_hi;
                alu_b   = r_lo[0] ? r_mcand : '0;
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = start ? c_ST_RUN : c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Operand capture, shift-add iteration and final sign correction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand <= w_mag_a;
            r_hi    <= '0;
            r_lo    <= w_mag_b;
            r_cnt   <= '0;
            r_neg   <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        end else if (w_running) begin
            r_hi  <= w_step[2*WIDTH-1:WIDTH];
            r_lo  <= w_step[WIDTH-1:0];
            r_cnt <= r_cnt + c_CNT_ONE;
            // Negation is local so the shared adder is released on time.
            if (w_last) begin
                r_product <= r_neg ? -w_step : w_step;
            end
        end
    end

    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_sequencer
//  Purpose  : Self-checking bench for mul_sequencer with an arithmetic
//             reference model and the shared adder modelled alongside.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mul_sequencer;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          signed_op;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  alu_sum;
    logic          alu_cout;
    logic          alu_req;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic          busy;
    logic          done;
    logic [2*W-1:0] product;

    int n_pass  = 0;
    int n_total = 0;

    mul_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signed_op (signed_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .alu_sum   (alu_sum),
        .alu_cout  (alu_cout),
        .alu_req   (alu_req),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    // Shared execute-stage adder.
    assign {alu_cout, alu_sum} = {1'b0, alu_a} + {1'b0, alu_b};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic s);
        if (s && $signed(x) < 0) return W'(-int'($signed(x)));
        return x;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: transaction level, arithmetic only.
    // ------------------------------------------------------------------
    bit             m_valid = 0;
    bit             m_run   = 0;
    bit             m_done  = 0;
    int             m_iter  = 0;
    logic [W-1:0]   m_mc, m_mp;
    logic [2*W-1:0] m_target;
    logic [2*W-1:0] m_product = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_iter = 0; m_product = '0;
        end else if (!m_run && start) begin
            m_run  = 1; m_done = 0; m_iter = 0;
            m_mc   = mag(op_a, signed_op);
            m_mp   = mag(op_b, signed_op);
            if (signed_op)
                m_target = 32'(longint'($signed(op_a)) * longint'($signed(op_b)));
            else
                m_target = 32'(longint'(op_a) * longint'(op_b));
        end else if (m_run) begin
            m_iter++;
            if (m_iter == W) begin
                m_run = 0; m_done = 1; m_product = m_target;
            end
        end else begin
            m_done = 0;
        end
        m_valid = 1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            logic [W-1:0] e_a, e_b;
            longint       part;
            e_a = '0; e_b = '0;
            if (m_run) begin
                // After k steps the high half holds (mcand * low k bits of mplier) >> k.
                part = longint'(m_mc) * longint'(m_mp & W'((1 << m_iter) - 1));
                e_a  = W'(part >> m_iter);
                e_b  = m_mp[m_iter] ? m_mc : '0;
            end
            chk("busy",    64'(busy),    64'(m_run));
            chk("alu_req", 64'(alu_req), 64'(m_run));
            chk("done",    64'(done),    64'(m_done));
            chk("alu_a",   64'(alu_a),   64'(e_a));
            chk("alu_b",   64'(alu_b),   64'(e_b));
            chk("product", 64'(product), 64'(m_product));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        op_a = a; op_b = b; signed_op = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits from within the cycle after the accepting edge; lat counts the
    // start cycle plus every cycle up to and including the done cycle.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i + 1;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    int lat;

    initial begin
        rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",    64'(busy),    64'd0);
        chk("rst_done",    64'(done),    64'd0);
        chk("rst_product", 64'(product), 64'd0);
        chk("rst_alu",     64'({alu_req, alu_a, alu_b}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle ownership: nothing driven on the adder port.
        repeat (20) @(posedge clk);
        #1;
        chk("idle_outs", 64'({alu_req, alu_a, alu_b, busy, done}), 64'd0);

        // Directed products with hand-computed results.
        do_start(16'd3, 16'd5, 1'b0);
        wait_done(lat);
        chk("lat_3x5", 64'(lat), 64'd17);
        chk("p_3x5", 64'(product), 64'h0000_000F);

        do_start(16'hFFFF, 16'hFFFF, 1'b0);
        wait_done(lat);
        chk("p_ffff_sq", 64'(product), 64'hFFFE_0001);

        do_start(16'hFFFD, 16'h0005, 1'b1);
        wait_done(lat);
        chk("p_m3x5", 64'(product), 64'hFFFF_FFF1);

        do_start(16'h8000, 16'h8000, 1'b1);
        wait_done(lat);
        chk("p_min_sq", 64'(product), 64'h4000_0000);

        // Back-to-back: new start issued in the DONE cycle of 2 x 2.
        do_start(16'd2, 16'd2, 1'b0);
        wait_done(lat);
        op_a = 16'd7; op_b = 16'd9; signed_op = 1'b0; start = 1'b1;
        chk("p_2x2", 64'(product), 64'h0000_0004);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_done_pulse", 64'(done), 64'd0);
        chk("b2b_busy",       64'(busy), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        op_a = 16'h1111; op_b = 16'h2222; start = 1'b1;   // ignored while running
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_hold", 64'(product), 64'h0000_0004);
        for (int i = 6; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i + 1; break; end
            lat = -1;
        end
        chk("lat_b2b", 64'(lat), 64'd17);
        chk("p_7x9",   64'(product), 64'h0000_003F);

        // Reset part-way through an operation.
        do_start(16'h1234, 16'h0010, 1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy",    64'(busy),    64'd0);
        chk("midrst_done",    64'(done),    64'd0);
        chk("midrst_product", 64'(product), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_start(16'h1234, 16'h0010, 1'b0);
        wait_done(lat);
        chk("p_1234x10", 64'(product), 64'h0001_2340);

        // Random traffic, including starts during RUN and in DONE.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start     = ($urandom_range(0, 3) == 0);
            signed_op = $urandom_range(0, 1) == 1;
            op_a      = W'($urandom);
            op_b      = W'($urandom);
            if ($urandom_range(0, 7) == 0) op_a = 16'h8000;
            if ($urandom_range(0, 7) == 0) op_b = 16'hFFFF;
        end
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
